weight_bank_scheduler: RTL and testbench

// Sequences the two weight-memory ping-pong banks: streams layer weights from a loader into the

---
 rtl/weight_bank_scheduler_if.sv | 48 ++++
 rtl/weight_bank_scheduler.sv | 174 +++++++++++++++++
 tb/tb_weight_bank_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_bank_scheduler_if.sv
// Handshake and memory-side signals between the weight-bank scheduler and its loader, memory and compute sequencer.
// The scheduler takes the slave side; the environment (loader/sequencer/bench) takes the master side.
interface weight_bank_scheduler_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int N      = 4,
    parameter int LEN_W  = 15
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic                  cfg_mode;
    logic [ADDR_W-2:0]     cfg_base;
    logic [LEN_W-1:0]      cfg_len;

    logic                  ld_valid;
    logic                  ld_ready;
    logic [N*DATA_W-1:0]   ld_data;

    logic                  wr_en_fc;
    logic                  wr_en_cnn;
    logic [ADDR_W-1:0]     wr_addr;
    logic [N*DATA_W-1:0]   wr_data;

    logic                  start_req;
    logic                  grant;
    logic                  layer_done;
    logic [ADDR_W-1:0]     weight_memory_pointer;
    logic                  mode;
    logic [1:0]            bank_full;

    modport slave (
        input  cfg_valid, cfg_mode, cfg_base, cfg_len,
        input  ld_valid, ld_data,
        input  start_req, layer_done,
        output cfg_ready, ld_ready,
        output wr_en_fc, wr_en_cnn, wr_addr, wr_data,
        output grant, weight_memory_pointer, mode, bank_full
    );

    modport master (
        output cfg_valid, cfg_mode, cfg_base, cfg_len,
        output ld_valid, ld_data,
        output start_req, layer_done,
        input  cfg_ready, ld_ready,
        input  wr_en_fc, wr_en_cnn, wr_addr, wr_data,
        input  grant, weight_memory_pointer, mode, bank_full
    );
endinterface

// File: rtl/weight_bank_scheduler.sv
// Ping-pong weight-bank scheduler: fills the free bank from the loader while compute reads the other.
// Writes land 1 cycle after the loader handshake, grant 1 cycle after the decision; ready flags are registered look-ahead.
module weight_bank_scheduler #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int N      = 4,
    parameter int LEN_W  = 15
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    weight_bank_scheduler_if.slave bus
);
    localparam int OFF_W = ADDR_W - 1;

    typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_ACTIVE} bank_st_t;
    typedef enum logic {S_IDLE, S_LOAD} ld_st_t;

    ld_st_t              r_state, w_state_nxt;
    bank_st_t            r_bst [2];
    bank_st_t            w_bst_nxt [2];
    logic                r_bmode [2];
    logic                w_bmode_nxt [2];
    logic [OFF_W-1:0]    r_bbase [2];
    logic [OFF_W-1:0]    w_bbase_nxt [2];
    logic                r_wr_bank, w_wr_bank_nxt;
    logic                r_rd_bank, w_rd_bank_nxt;
    logic [LEN_W-1:0]    r_len, w_len_nxt;
    logic [LEN_W-1:0]    r_cnt, w_cnt_nxt;
    logic [OFF_W-1:0]    r_base, w_base_nxt;
    logic                r_mode_ld, w_mode_ld_nxt;
    logic                r_cfg_ready, w_cfg_ready_nxt;
    logic                r_ld_ready, w_ld_ready_nxt;
    logic                r_wr_en_fc, w_wr_en_fc_nxt;
    logic                r_wr_en_cnn, w_wr_en_cnn_nxt;
    logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_nxt;
    logic [N*DATA_W-1:0] r_wr_data, w_wr_data_nxt;
    logic                r_grant, w_grant_nxt;
    logic [ADDR_W-1:0]   r_ptr, w_ptr_nxt;
    logic                r_mode, w_mode_nxt;

    logic w_cfg_hs, w_ld_hs, w_any_active;

    // Ready flags are registered, so they already encode "IDLE and target bank FREE" / "LOAD".
    assign w_cfg_hs     = bus.cfg_valid && r_cfg_ready;
    assign w_ld_hs      = bus.ld_valid && r_ld_ready;
    assign w_any_active = (r_bst[0] == B_ACTIVE) || (r_bst[1] == B_ACTIVE);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            for (int b = 0; b < 2; b++) begin
                r_bst[b]   <= B_FREE;
                r_bmode[b] <= 1'b0;
                r_bbase[b] <= '0;
            end
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_base      <= '0;
            r_mode_ld   <= 1'b0;
            r_cfg_ready <= 1'b0;
            r_ld_ready  <= 1'b0;
            r_wr_en_fc  <= 1'b0;
            r_wr_en_cnn <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_grant     <= 1'b0;
            r_ptr       <= '0;
            r_mode      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bst       <= w_bst_nxt;
            r_bmode     <= w_bmode_nxt;
            r_bbase     <= w_bbase_nxt;
            r_wr_bank   <= w_wr_bank_nxt;
            r_rd_bank   <= w_rd_bank_nxt;
            r_len       <= w_len_nxt;
            r_cnt       <= w_cnt_nxt;
            r_base      <= w_base_nxt;
            r_mode_ld   <= w_mode_ld_nxt;
            r_cfg_ready <= w_cfg_ready_nxt;
            r_ld_ready  <= w_ld_ready_nxt;
            r_wr_en_fc  <= w_wr_en_fc_nxt;
            r_wr_en_cnn <= w_wr_en_cnn_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_grant     <= w_grant_nxt;
            r_ptr       <= w_ptr_nxt;
            r_mode      <= w_mode_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_bst_nxt       = r_bst;
        w_bmode_nxt     = r_bmode;
        w_bbase_nxt     = r_bbase;
        w_wr_bank_nxt   = r_wr_bank;
        w_rd_bank_nxt   = r_rd_bank;
        w_len_nxt       = r_len;
        w_cnt_nxt       = r_cnt;
        w_base_nxt      = r_base;
        w_mode_ld_nxt   = r_mode_ld;
        w_wr_en_fc_nxt  = 1'b0;
        w_wr_en_cnn_nxt = 1'b0;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;
        w_grant_nxt     = 1'b0;
        w_ptr_nxt       = r_ptr;
        w_mode_nxt      = r_mode;

        if (r_state == S_IDLE) begin
            if (w_cfg_hs) begin
                w_bmode_nxt[r_wr_bank] = bus.cfg_mode;
                w_bbase_nxt[r_wr_bank] = bus.cfg_base;
                w_len_nxt              = bus.cfg_len;
                w_base_nxt             = bus.cfg_base;
                w_mode_ld_nxt          = bus.cfg_mode;
                w_cnt_nxt              = '0;
                // An empty layer is complete the moment it is described.
                if (bus.cfg_len == '0) begin
                    w_bst_nxt[r_wr_bank] = B_FULL;
                    w_wr_bank_nxt        = ~r_wr_bank;
                end else begin
                    w_bst_nxt[r_wr_bank] = B_FILLING;
                    w_state_nxt          = S_LOAD;
                end
            end
        end else begin
            if (w_ld_hs) begin
                w_wr_en_fc_nxt  = ~r_mode_ld;
                w_wr_en_cnn_nxt = r_mode_ld;
                // Offset addition truncates to the in-bank width, so wrap never touches the bank bit.
                w_wr_addr_nxt   = {r_wr_bank, r_base + OFF_W'(r_cnt)};
                w_wr_data_nxt   = bus.ld_data;
                w_cnt_nxt       = r_cnt + LEN_W'(1);
                if (r_cnt == r_len - LEN_W'(1)) begin
                    w_bst_nxt[r_wr_bank] = B_FULL;
                    w_wr_bank_nxt        = ~r_wr_bank;
                    w_state_nxt          = S_IDLE;
                end
            end
        end

        if (bus.start_req && !w_any_active && r_bst[r_rd_bank] == B_FULL) begin
            w_bst_nxt[r_rd_bank] = B_ACTIVE;
            w_grant_nxt          = 1'b1;
            w_ptr_nxt            = {r_rd_bank, r_bbase[r_rd_bank]};
            w_mode_nxt           = r_bmode[r_rd_bank];
        end

        // Only the read bank can be ACTIVE, so layer_done always frees it.
        if (bus.layer_done && r_bst[r_rd_bank] == B_ACTIVE) begin
            w_bst_nxt[r_rd_bank] = B_FREE;
            w_rd_bank_nxt        = ~r_rd_bank;
        end

        w_cfg_ready_nxt = (w_state_nxt == S_IDLE) && (w_bst_nxt[w_wr_bank_nxt] == B_FREE);
        w_ld_ready_nxt  = (w_state_nxt == S_LOAD);
    end

    assign bus.cfg_ready             = r_cfg_ready;
    assign bus.ld_ready              = r_ld_ready;
    assign bus.wr_en_fc              = r_wr_en_fc;
    assign bus.wr_en_cnn             = r_wr_en_cnn;
    assign bus.wr_addr               = r_wr_addr;
    assign bus.wr_data               = r_wr_data;
    assign bus.grant                 = r_grant;
    assign bus.weight_memory_pointer = r_ptr;
    assign bus.mode                  = r_mode;
    assign bus.bank_full[0]          = (r_bst[0] == B_FULL) || (r_bst[0] == B_ACTIVE);
    assign bus.bank_full[1]          = (r_bst[1] == B_FULL) || (r_bst[1] == B_ACTIVE);
endmodule

// File: tb/tb_weight_bank_scheduler.sv
// Directed scenarios plus random traffic, checked every cycle against a bank-occupancy / layer-queue model.
module tb_weight_bank_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    weight_bank_scheduler_if bus ();
    weight_bank_scheduler dut (.i_clk(clk), .i_reset(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [15:0] ptr;
    } layer_t;

    // Reference model: banks fill and drain in strict alternation, so occupancy plus a layer FIFO suffices.
    int          m_occ;
    logic        m_first, m_loading, m_active;
    logic [1:0]  m_full;
    logic        m_wbank, m_rbank;
    logic [14:0] m_base;
    int          m_len, m_cnt;
    logic        m_mode;
    layer_t      m_lay_q[$];
    layer_t      m_gexp;
    logic        m_gpend;
    logic        m_wpend;
    logic [15:0] m_waddr;
    logic [31:0] m_wdata;
    logic        m_wmode;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_occ = 0; m_first = 1'b1; m_loading = 1'b0; m_active = 1'b0; m_full = 2'b00;
        m_wbank = 1'b0; m_rbank = 1'b0; m_base = '0; m_len = 0; m_cnt = 0; m_mode = 1'b0;
        m_lay_q.delete(); m_gpend = 1'b0; m_wpend = 1'b0;
    endtask

    task automatic complete(input logic md, input logic [14:0] base);
        layer_t l;
        l.mode = md;
        l.ptr  = {m_wbank, base};
        m_lay_q.push_back(l);
        m_full[m_wbank] = 1'b1;
        m_wbank = ~m_wbank;
    endtask

    always @(negedge clk) begin
        logic e_crdy, e_lrdy, hs_c, hs_l, gcond, done, nw;
        if (!rst_n) begin
            check("rst_ctl", {bus.cfg_ready, bus.ld_ready, bus.wr_en_fc, bus.wr_en_cnn,
                              bus.grant, bus.mode, bus.bank_full}, 64'd0);
            check("rst_addr_ptr", {bus.wr_addr, bus.weight_memory_pointer}, 64'd0);
            check("rst_data", bus.wr_data, 64'd0);
            model_reset();
        end else begin
            e_crdy = !m_first && !m_loading && (m_occ < 2);
            e_lrdy = m_loading;
            check("cfg_ready", bus.cfg_ready, e_crdy);
            check("ld_ready", bus.ld_ready, e_lrdy);
            check("wr_en_fc", bus.wr_en_fc, m_wpend && !m_wmode);
            check("wr_en_cnn", bus.wr_en_cnn, m_wpend && m_wmode);
            if (m_wpend) begin
                check("wr_addr", bus.wr_addr, m_waddr);
                check("wr_data", bus.wr_data, m_wdata);
            end
            check("grant", bus.grant, m_gpend);
            if (m_gpend) begin
                check("pointer", bus.weight_memory_pointer, m_gexp.ptr);
                check("mode", bus.mode, m_gexp.mode);
            end
            check("bank_full", bus.bank_full, m_full);

            hs_c    = bus.cfg_valid && e_crdy;
            hs_l    = bus.ld_valid && e_lrdy;
            gcond   = bus.start_req && !m_active && (m_lay_q.size() > 0);
            done    = bus.layer_done && m_active;
            nw      = 1'b0;
            m_first = 1'b0;
            if (gcond) begin
                m_gexp   = m_lay_q.pop_front();
                m_active = 1'b1;
            end
            if (done) begin
                m_active        = 1'b0;
                m_full[m_rbank] = 1'b0;
                m_rbank         = ~m_rbank;
                m_occ--;
            end
            if (hs_c) begin
                m_occ++;
                if (bus.cfg_len == 0) complete(bus.cfg_mode, bus.cfg_base);
                else begin
                    m_loading = 1'b1; m_len = int'(bus.cfg_len); m_cnt = 0;
                    m_base = bus.cfg_base; m_mode = bus.cfg_mode;
                end
            end
            if (hs_l) begin
                nw      = 1'b1;
                m_waddr = {m_wbank, 15'(m_base + m_cnt)};
                m_wdata = bus.ld_data;
                m_wmode = m_mode;
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_loading = 1'b0;
                    complete(m_mode, m_base);
                end
            end
            m_wpend = nw;
            m_gpend = gcond;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cfg_valid = 1'b0; bus.cfg_mode = 1'b0; bus.cfg_base = '0; bus.cfg_len = '0;
        bus.ld_valid = 1'b0; bus.ld_data = '0; bus.start_req = 1'b0; bus.layer_done = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) tick();
        check("rst_bank_full", bus.bank_full, 64'd0);
        rst_n = 1'b1;
    endtask

    task automatic send_desc(input logic md, input logic [14:0] base, input logic [14:0] len);
        logic ok = 1'b0;
        bus.cfg_valid = 1'b1; bus.cfg_mode = md; bus.cfg_base = base; bus.cfg_len = len;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.cfg_ready;
            tick();
        end
        bus.cfg_valid = 1'b0;
        check("cfg_accept", ok, 64'd1);
    endtask

    task automatic send_words(input int n);
        for (int w = 0; w < n; w++) begin
            logic ok = 1'b0;
            bus.ld_valid = 1'b1;
            bus.ld_data  = $urandom;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk);
                ok = bus.ld_ready;
                tick();
            end
            check("ld_accept", ok, 64'd1);
        end
        bus.ld_valid = 1'b0;
    endtask

    task automatic request_grant();
        logic got = 1'b0;
        bus.start_req = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = bus.grant;
            tick();
        end
        bus.start_req = 1'b0;
        check("grant_seen", got, 64'd1);
    endtask

    task automatic pulse_done();
        bus.layer_done = 1'b1;
        tick();
        bus.layer_done = 1'b0;
    endtask

    task automatic full_to_grant_test();
        int f = -1;
        int g = -1;
        bus.start_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_grant_empty", bus.grant, 64'd0);
            tick();
        end
        fork
            begin
                send_desc(1'b0, 15'h0040, 15'd2);
                send_words(2);
            end
            for (int i = 0; i < 40 && g < 0; i++) begin
                @(negedge clk);
                if (f < 0 && bus.bank_full[1]) f = i;
                if (bus.grant) g = i;
            end
        join
        tick();
        bus.start_req = 1'b0;
        check("full_to_grant", 64'(g - f), 64'd1);
        pulse_done();
    endtask

    initial begin
        logic acc_c, acc_l, g;
        rst_n = 1'b0;
        idle_inputs();
        apply_reset();

        // FC layer into bank 0, then grant it.
        send_desc(1'b0, 15'h0010, 15'd3);
        send_words(3);
        check("t1_bank_full", bus.bank_full, 64'h1);
        request_grant();
        check("t1_ptr", bus.weight_memory_pointer, 64'h0010);
        check("t1_mode", bus.mode, 64'd0);

        // CNN layer into bank 1 while bank 0 is active; third descriptor blocked.
        send_desc(1'b1, 15'h0020, 15'd2);
        send_words(2);
        check("t2_bank_full", bus.bank_full, 64'h3);
        bus.cfg_valid = 1'b1; bus.cfg_mode = 1'b0; bus.cfg_base = 15'h0030; bus.cfg_len = '0;
        repeat (4) begin
            @(negedge clk);
            check("t2_blocked", bus.cfg_ready, 64'd0);
            tick();
        end
        bus.layer_done = 1'b1;
        @(negedge clk);
        check("t5_same_cycle_rdy", bus.cfg_ready, 64'd0);
        tick();
        bus.layer_done = 1'b0;
        @(negedge clk);
        check("t5_next_cycle_rdy", bus.cfg_ready, 64'd1);
        tick();
        bus.cfg_valid = 1'b0;
        check("t5_len0_full", bus.bank_full, 64'h3);
        request_grant();
        check("t2_ptr", bus.weight_memory_pointer, 64'h8020);
        check("t2_mode", bus.mode, 64'd1);
        pulse_done();
        request_grant();
        check("t5_ptr", bus.weight_memory_pointer, 64'h0030);
        pulse_done();
        check("all_free", bus.bank_full, 64'd0);

        full_to_grant_test();

        // In-bank address wrap on bank 0.
        send_desc(1'b0, 15'h7FFE, 15'd4);
        send_words(4);
        check("wrap_last_addr", bus.wr_addr, 64'h0001);
        request_grant();
        check("wrap_ptr", bus.weight_memory_pointer, 64'h7FFE);
        pulse_done();

        // Reset in the middle of a load into bank 1.
        send_desc(1'b1, 15'h0100, 15'd5);
        send_words(2);
        apply_reset();
        send_desc(1'b1, 15'h0055, 15'd1);
        send_words(1);
        check("post_rst_addr", bus.wr_addr, 64'h0055);
        check("post_rst_cnn", bus.wr_en_cnn, 64'd1);

        // Random traffic; the model checks every cycle.
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            acc_c = bus.cfg_valid && bus.cfg_ready;
            acc_l = bus.ld_valid && bus.ld_ready;
            g     = bus.grant;
            tick();
            if (acc_c || !bus.cfg_valid) begin
                bus.cfg_valid = ($urandom_range(0, 3) == 0);
                bus.cfg_mode  = 1'($urandom_range(0, 1));
                bus.cfg_base  = ($urandom_range(0, 3) == 0) ? 15'(32'h7FFC + $urandom_range(0, 3))
                                                             : 15'($urandom);
                bus.cfg_len   = 15'($urandom_range(0, 6));
            end
            if (acc_l || !bus.ld_valid) begin
                bus.ld_valid = 1'($urandom_range(0, 1));
                bus.ld_data  = $urandom;
            end
            if (g) bus.start_req = 1'b0;
            else if (!bus.start_req) bus.start_req = ($urandom_range(0, 3) == 0);
            bus.layer_done = ($urandom_range(0, 5) == 0);
        end
        idle_inputs();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "timeout");
    end
endmodule
